approx_lod_mult_seq: RTL

- Parametrised, sequential approximate unsigned multiplier; successor to the combinational 8-bit leading-one-detect truncating multiplier.
- Finds the leading one of multiplier B and keeps only K bits from it downward; lower bits are dropped, with optional round-half-up.
- Accumulates A times the kept field by iterative shift-add, one partial product per clock.
- Sits between operand registers and the accumulator datapath, with valid/ready handshakes on both sides.

---
 rtl/approx_mult_pkg.sv | 23 ++
 rtl/lod_enc.sv | 25 ++
 rtl/approx_lod_mult_seq.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/approx_mult_pkg.sv
// Shared types and width helpers for the approximate-multiplier family.
// No logic; constant functions only, evaluated at elaboration.
// Imported by lod_enc and approx_lod_mult_seq.
package approx_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOD  = 2'd1,
    ST_ACC  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Step counter must hold 0..K (K+1 accumulate steps) with headroom.
  function automatic int cnt_width(input int k);
    return $clog2(k + 2);
  endfunction

  // Bit-position width for a W-bit operand.
  function automatic int pos_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/lod_enc.sv
// Leading-one detector: W-bit vector -> index of highest set bit plus zero flag.
// Latency: combinational.
// Backpressure: none (pure function of the input).
module lod_enc
  import approx_mult_pkg::*;
#(
  parameter int W  = 8,
  parameter int PW = pos_width(W)
) (
  input  logic [W-1:0]  i_vec,
  output logic [PW-1:0] o_pos,
  output logic          o_zero
);

  // Scan upward so the highest set bit is the last one written.
  always_comb begin
    o_pos = '0;
    for (int i = 0; i < W; i++) begin
      if (i_vec[i]) o_pos = PW'(i);
    end
  end

  assign o_zero = ~|i_vec;

endmodule

// File: rtl/approx_lod_mult_seq.sv
// Sequential approximate multiplier: keep K bits of b from its leading one, shift-add A.
// Latency: accept cycle, 1 LOD cycle, K+1 ACC cycles, then DONE (out_valid in cycle K+3).
// Backpressure: DONE holds p_o/trunc_o indefinitely while out_ready is low; in_ready only in IDLE.
module approx_lod_mult_seq
  import approx_mult_pkg::*;
#(
  parameter int W     = 8,
  parameter int K     = 5,
  parameter int ROUND = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p_o,
  output logic           trunc_o
);

  localparam int PW = pos_width(W);
  localparam int CW = cnt_width(K);
  localparam int AW = 2 * W;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [PW-1:0]   r_p;
  logic [PW-1:0]   r_lo;
  logic            r_rbit;
  logic            r_trunc;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_acc;

  logic [PW-1:0]   w_pos;
  logic            w_zero;
  logic [PW-1:0]   w_lo;
  logic [W-1:0]    w_mask;
  logic            w_trunc;
  logic            w_rbit;
  logic [PW-1:0]   w_bitpos;
  logic [AW-1:0]   w_addend;
  logic            w_last;

  lod_enc #(.W(W), .PW(PW)) u_lod (
    .i_vec  (r_b),
    .o_pos  (w_pos),
    .o_zero (w_zero)
  );

  // Truncation window: lowest kept bit, dropped-bit flag and rounding bit.
  always_comb begin
    w_lo = '0;
    if (!w_zero && (int'(w_pos) >= K - 1)) w_lo = PW'(int'(w_pos) - K + 1);
    w_mask  = (W'(1) << w_lo) - W'(1);
    w_trunc = (w_lo != '0) && ((r_b & w_mask) != '0);
    w_rbit  = 1'b0;
    if (ROUND != 0) w_rbit = (w_lo != '0) && r_b[w_lo - PW'(1)];
  end

  // Partial product for the current step: one kept bit, or the rounding LSB on the last step.
  always_comb begin
    w_addend = '0;
    w_bitpos = '0;
    w_last   = (r_cnt == CW'(K));
    if (int'(r_cnt) < K) begin
      if (int'(r_p) - int'(r_cnt) >= int'(r_lo)) begin
        w_bitpos = r_p - PW'(r_cnt);
        if (r_b[w_bitpos]) w_addend = {{W{1'b0}}, r_a} << w_bitpos;
      end
    end else if (r_rbit) begin
      w_addend = {{W{1'b0}}, r_a} << r_lo;
    end
  end

  // Control FSM and datapath registers; all outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_acc       <= '0;
      r_trunc     <= 1'b0;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_p         <= '0;
      r_lo        <= '0;
      r_rbit      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a        <= a_i;
            r_b        <= b_i;
            r_acc      <= '0;
            r_trunc    <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= ST_LOD;
          end
        end
        ST_LOD: begin
          r_p     <= w_pos;
          r_lo    <= w_lo;
          r_rbit  <= w_rbit;
          r_trunc <= w_trunc;
          r_cnt   <= '0;
          r_state <= ST_ACC;
        end
        ST_ACC: begin
          r_acc <= r_acc + w_addend;
          if (w_last) begin
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign p_o       = r_acc;
  assign trunc_o   = r_trunc;

endmodule
